// File: rtl/barrel_shifter_sequencer.sv
// Multi-pass shift sequencer: iterates an 8-bit barrel shifter (at most 7 bits per
// pass) to realise a shift of any length up to 2^LEN_W-1 bits.

module Barrel_Shifter_8_Bit (
    input  logic       Enable_In,
    input  logic [2:0] Mode_In,
    input  logic [2:0] Shift_Bits_Length_In,
    input  logic       Carry_In,
    input  logic [7:0] Data_In,
    output logic [7:0] Shifted_Data_Out,
    output logic       Carry_Out
);

    logic [15:0] wide;
    logic [17:0] wide9;

    // Carry out is the last bit moved past the end; RLC/RRC rotate {carry, data} as 9 bits.
    always_comb begin
        wide             = '0;
        wide9            = '0;
        Shifted_Data_Out = Data_In;
        Carry_Out        = Carry_In;
        if (Enable_In && (Shift_Bits_Length_In != 3'd0)) begin
            case (Mode_In)
                3'd0, 3'd2: begin
                    wide             = {8'h00, Data_In} << Shift_Bits_Length_In;
                    Shifted_Data_Out = wide[7:0];
                    Carry_Out        = wide[8];
                end
                3'd1: begin
                    wide             = {Data_In, 8'h00} >> Shift_Bits_Length_In;
                    Shifted_Data_Out = wide[15:8];
                    Carry_Out        = wide[7];
                end
                3'd3: begin
                    wide             = $signed({Data_In, 8'h00}) >>> Shift_Bits_Length_In;
                    Shifted_Data_Out = wide[15:8];
                    Carry_Out        = wide[7];
                end
                3'd4: begin
                    wide             = {Data_In, Data_In} << Shift_Bits_Length_In;
                    Shifted_Data_Out = wide[15:8];
                    Carry_Out        = wide[8];
                end
                3'd5: begin
                    wide             = {Data_In, Data_In} >> Shift_Bits_Length_In;
                    Shifted_Data_Out = wide[7:0];
                    Carry_Out        = wide[7];
                end
                3'd6: begin
                    wide9                       = {Carry_In, Data_In, Carry_In, Data_In} << Shift_Bits_Length_In;
                    {Carry_Out, Shifted_Data_Out} = wide9[17:9];
                end
                default: begin
                    wide9                       = {Carry_In, Data_In, Carry_In, Data_In} >> Shift_Bits_Length_In;
                    {Carry_Out, Shifted_Data_Out} = wide9[8:0];
                end
            endcase
        end
    end

endmodule

module barrel_shifter_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic             Clock_In,
    input  logic             Reset_In,
    input  logic             Cmd_Valid_In,
    output logic             Cmd_Ready_Out,
    input  logic [2:0]       Cmd_Mode_In,
    input  logic [LEN_W-1:0] Cmd_Length_In,
    input  logic             Cmd_Carry_In,
    input  logic [7:0]       Cmd_Data_In,
    output logic             Rsp_Valid_Out,
    input  logic             Rsp_Ready_In,
    output logic [7:0]       Rsp_Data_Out,
    output logic             Rsp_Carry_Out,
    output logic             Busy_Out
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       mode_q, mode_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [7:0]       data_q, data_d;
    logic             carry_q, carry_d;

    logic [2:0]       step;
    logic             shiftEnable;
    logic [7:0]       shiftedData;
    logic             shiftedCarry;

    assign step        = (remaining_q >= LEN_W'(7)) ? 3'd7 : remaining_q[2:0];
    assign shiftEnable = (state_q == SHIFT);

    Barrel_Shifter_8_Bit shifter (
        .Enable_In            (shiftEnable),
        .Mode_In              (mode_q),
        .Shift_Bits_Length_In (step),
        .Carry_In             (carry_q),
        .Data_In              (data_q),
        .Shifted_Data_Out     (shiftedData),
        .Carry_Out            (shiftedCarry)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        carry_d     = carry_q;
        case (state_q)
            IDLE: begin
                if (Cmd_Valid_In) begin
                    mode_d      = Cmd_Mode_In;
                    remaining_d = Cmd_Length_In;
                    data_d      = Cmd_Data_In;
                    carry_d     = Cmd_Carry_In;
                    state_d     = (Cmd_Length_In == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                // SHIFT is only entered or held with remaining > 0, so step is never 0 here.
                data_d      = shiftedData;
                carry_d     = shiftedCarry;
                remaining_d = remaining_q - LEN_W'(step);
                if (remaining_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (Rsp_Ready_In) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock_In) begin
        if (!Reset_In) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            carry_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
            carry_q     <= carry_d;
        end
    end

    assign Cmd_Ready_Out = (state_q == IDLE);
    assign Rsp_Valid_Out = (state_q == DONE);
    assign Busy_Out      = (state_q != IDLE);
    assign Rsp_Data_Out  = data_q;
    assign Rsp_Carry_Out = carry_q;

endmodule

// File: tb/tb_barrel_shifter_sequencer.sv
// Bench for barrel_shifter_sequencer: bit-at-a-time reference model with a per-cycle
// compare process, directed cases with literal expectations, then random commands.

module tb_barrel_shifter_sequencer;

    localparam int LEN_W = 8;

    logic             clock;
    logic             rstN;
    logic             cmdValid;
    logic             cmdReady;
    logic [2:0]       cmdMode;
    logic [LEN_W-1:0] cmdLength;
    logic             cmdCarry;
    logic [7:0]       cmdData;
    logic             rspValid;
    logic             rspReady;
    logic [7:0]       rspData;
    logic             rspCarry;
    logic             busy;

    int compared   = 0;
    int mismatched = 0;
    bit checkEn    = 0;

    // Reference state: idle / result-ready flags and passes still to run.
    bit       mIdle   = 1;
    bit       mDone   = 0;
    int       mPasses = 0;
    logic [7:0] expData  = 8'h00;
    logic       expCarry = 1'b0;

    barrel_shifter_sequencer #(.LEN_W(LEN_W)) dut (
        .Clock_In      (clock),
        .Reset_In      (rstN),
        .Cmd_Valid_In  (cmdValid),
        .Cmd_Ready_Out (cmdReady),
        .Cmd_Mode_In   (cmdMode),
        .Cmd_Length_In (cmdLength),
        .Cmd_Carry_In  (cmdCarry),
        .Cmd_Data_In   (cmdData),
        .Rsp_Valid_Out (rspValid),
        .Rsp_Ready_In  (rspReady),
        .Rsp_Data_Out  (rspData),
        .Rsp_Carry_Out (rspCarry),
        .Busy_Out      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Performs an n-bit operation one single bit at a time.
    function automatic logic [8:0] refShift(input logic [2:0] m, input int n,
                                            input logic c, input logic [7:0] d);
        logic [7:0] x;
        logic       cy;
        logic       t;
        x  = d;
        cy = c;
        for (int i = 0; i < n; i++) begin
            case (m)
                3'd0, 3'd2: begin cy = x[7]; x = {x[6:0], 1'b0}; end
                3'd1:       begin cy = x[0]; x = {1'b0, x[7:1]}; end
                3'd3:       begin cy = x[0]; x = {x[7], x[7:1]}; end
                3'd4:       begin x = {x[6:0], x[7]}; cy = x[0]; end
                3'd5:       begin x = {x[0], x[7:1]}; cy = x[7]; end
                3'd6:       begin t = x[7]; x = {x[6:0], cy}; cy = t; end
                default:    begin t = x[0]; x = {cy, x[7:1]}; cy = t; end
            endcase
        end
        return {cy, x};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    always @(posedge clock) begin
        if (!rstN) begin
            mIdle    = 1;
            mDone    = 0;
            mPasses  = 0;
            expData  = 8'h00;
            expCarry = 1'b0;
        end else if (mIdle) begin
            if (cmdValid) begin
                {expCarry, expData} = refShift(cmdMode, int'(cmdLength), cmdCarry, cmdData);
                mIdle   = 0;
                mPasses = (int'(cmdLength) + 6) / 7;
                mDone   = (cmdLength == '0);
            end
        end else if (!mDone) begin
            mPasses--;
            if (mPasses == 0) mDone = 1;
        end else if (rspReady) begin
            mIdle = 1;
            mDone = 0;
        end
    end

    always @(negedge clock) begin
        if (checkEn) begin
            checkOutput("cmdReady", cmdReady, mIdle);
            checkOutput("rspValid", rspValid, mDone);
            checkOutput("busy", busy, !mIdle);
            if (mDone) begin
                checkOutput("rspData", rspData, expData);
                checkOutput("rspCarry", rspCarry, expCarry);
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] m, input logic [LEN_W-1:0] l,
                                 input logic c, input logic [7:0] d, input int hold,
                                 input bit pulse, output int latency, output int busyCycles,
                                 output logic [7:0] gotData, output logic gotCarry);
        int guard;
        guard = 0;
        latency = 0;
        busyCycles = 0;
        gotData = 8'h00;
        gotCarry = 1'b0;
        while (!cmdReady && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 100) begin
            checkOutput("cmdReadyTimeout", 0, 1);
            return;
        end
        cmdValid  = 1'b1;
        cmdMode   = m;
        cmdLength = l;
        cmdCarry  = c;
        cmdData   = d;
        @(negedge clock);
        cmdValid = 1'b0;
        cmdData  = 8'($urandom);
        cmdLength = LEN_W'($urandom);
        latency = 1;
        if (busy) busyCycles++;
        while (!rspValid && latency < 100) begin
            @(negedge clock);
            latency++;
            if (busy) busyCycles++;
        end
        if (!rspValid) begin
            checkOutput("rspValidTimeout", 0, 1);
            return;
        end
        gotData  = rspData;
        gotCarry = rspCarry;
        for (int i = 0; i < hold; i++) begin
            if (pulse && i == 2) begin
                cmdValid  = 1'b1;
                cmdMode   = 3'd0;
                cmdLength = '0;
                cmdCarry  = 1'b0;
                cmdData   = 8'h3C;
            end
            @(negedge clock);
            cmdValid = 1'b0;
            if (busy) busyCycles++;
        end
        rspReady = 1'b1;
        @(negedge clock);
        rspReady = 1'b0;
    endtask

    int         lat;
    int         busyN;
    logic [7:0] gotD;
    logic       gotC;

    initial begin
        rstN      = 1'b0;
        cmdValid  = 1'b0;
        cmdMode   = 3'd0;
        cmdLength = '0;
        cmdCarry  = 1'b0;
        cmdData   = 8'h00;
        rspReady  = 1'b0;
        repeat (2) @(negedge clock);
        rstN = 1'b1;
        checkEn = 1;
        $display("[TB] reset state");
        checkOutput("resetCmdReady", cmdReady, 1);
        checkOutput("resetRspValid", rspValid, 0);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetRspData", rspData, 8'h00);
        checkOutput("resetRspCarry", rspCarry, 0);

        $display("[TB] LSL 0x01 by 8");
        applyStimulus(3'd0, 8'd8, 1'b0, 8'h01, 0, 0, lat, busyN, gotD, gotC);
        checkOutput("lsl8Latency", lat, 3);
        checkOutput("lsl8Data", gotD, 8'h00);
        checkOutput("lsl8Carry", gotC, 1);

        $display("[TB] ROR 0xA5 by 20");
        applyStimulus(3'd5, 8'd20, 1'b0, 8'hA5, 0, 0, lat, busyN, gotD, gotC);
        checkOutput("ror20Latency", lat, 4);
        checkOutput("ror20Busy", busyN, 4);
        checkOutput("ror20Data", gotD, 8'h5A);

        $display("[TB] RLC 0x00 carry 1 by 9, ASR 0x80 by 10");
        applyStimulus(3'd6, 8'd9, 1'b1, 8'h00, 0, 0, lat, busyN, gotD, gotC);
        checkOutput("rlc9Data", gotD, 8'h00);
        checkOutput("rlc9Carry", gotC, 1);
        applyStimulus(3'd3, 8'd10, 1'b0, 8'h80, 0, 0, lat, busyN, gotD, gotC);
        checkOutput("asr10Data", gotD, 8'hFF);
        checkOutput("asr10Carry", gotC, 1);

        $display("[TB] length 0");
        applyStimulus(3'd4, 8'd0, 1'b1, 8'h3C, 0, 0, lat, busyN, gotD, gotC);
        checkOutput("len0Latency", lat, 1);
        checkOutput("len0Data", gotD, 8'h3C);
        checkOutput("len0Carry", gotC, 1);

        $display("[TB] backpressure for 5 cycles with ignored command pulse");
        applyStimulus(3'd0, 8'd8, 1'b0, 8'h01, 5, 1, lat, busyN, gotD, gotC);
        checkOutput("holdData", gotD, 8'h00);
        checkOutput("holdBusy", busyN, 8);
        checkOutput("holdAfterReady", cmdReady, 1);
        checkOutput("holdAfterValid", rspValid, 0);

        $display("[TB] reset during second pass of ROR 20");
        cmdValid  = 1'b1;
        cmdMode   = 3'd5;
        cmdLength = 8'd20;
        cmdCarry  = 1'b0;
        cmdData   = 8'hA5;
        @(negedge clock);
        cmdValid = 1'b0;
        @(negedge clock);
        rstN = 1'b0;
        @(negedge clock);
        rstN = 1'b1;
        checkOutput("midResetCmdReady", cmdReady, 1);
        checkOutput("midResetRspValid", rspValid, 0);
        checkOutput("midResetRspData", rspData, 8'h00);
        checkOutput("midResetBusy", busy, 0);

        $display("[TB] reset priority over command");
        rstN      = 1'b0;
        cmdValid  = 1'b1;
        cmdLength = '0;
        cmdData   = 8'h3C;
        @(negedge clock);
        rstN     = 1'b1;
        cmdValid = 1'b0;
        checkOutput("rstPrioCmdReady", cmdReady, 1);
        checkOutput("rstPrioRspValid", rspValid, 0);

        $display("[TB] random commands");
        for (int n = 0; n < 60; n++) begin
            logic [LEN_W-1:0] rl;
            rl = ($urandom_range(0, 4) == 0) ? LEN_W'($urandom_range(0, 255))
                                              : LEN_W'($urandom_range(0, 24));
            applyStimulus(3'($urandom_range(0, 7)), rl, 1'($urandom), 8'($urandom),
                          int'($urandom_range(0, 3)), bit'($urandom), lat, busyN, gotD, gotC);
            checkOutput("randLatency", lat, (rl == '0) ? 1 : ((int'(rl) + 6) / 7) + 1);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/barrel_shifter_sequencer.md
BARREL_SHIFTER_SEQUENCER -- requirements
Module: barrel_shifter_sequencer

Interface
REQ-001 SHALL have parameter LEN_W, default 8: width of the total shift length; legal range is 4 to 16.
REQ-002 SHALL have port Clock_In, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset_In, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port Cmd_Valid_In, input, 1 bit: a command is presented.
REQ-005 SHALL have port Cmd_Ready_Out, output, 1 bit: the block can accept a command.
REQ-006 SHALL have port Cmd_Mode_In, input, 3 bits: operation code with the same encoding as the 8-bit shifter (0 LSL, 1 LSR, 2 ASL, 3 ASR, 4 ROL, 5 ROR, 6 RLC, 7 RRC).
REQ-007 SHALL have port Cmd_Length_In, input, LEN_W bits: total shift length, 0 to 2^LEN_W-1.
REQ-008 SHALL have port Cmd_Carry_In, input, 1 bit: initial carry.
REQ-009 SHALL have port Cmd_Data_In, input, 8 bits: operand.
REQ-010 SHALL have port Rsp_Valid_Out, output, 1 bit: a result is available.
REQ-011 SHALL have port Rsp_Ready_In, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port Rsp_Data_Out, output, 8 bits: result data.
REQ-013 SHALL have port Rsp_Carry_Out, output, 1 bit: result carry.
REQ-014 SHALL have port Busy_Out, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 SHALL instantiate one Barrel_Shifter_8_Bit and iterate it to realise shifts longer than 7 bits.
REQ-016 SHALL implement a state machine with the states IDLE, SHIFT and DONE.
REQ-017 SHALL drive Cmd_Ready_Out = (state==IDLE), Rsp_Valid_Out = (state==DONE) and Busy_Out = (state!=IDLE).
REQ-018 SHALL accept a command on a rising edge in IDLE when Cmd_Valid_In=1, latching the mode, length, carry and data into internal registers.
REQ-019 SHALL ignore all Cmd_* inputs outside IDLE.
REQ-020 SHALL, on acceptance with length 0, load Rsp_Data_Out=Cmd_Data_In and Rsp_Carry_Out=Cmd_Carry_In and go straight to DONE, so Rsp_Valid_Out is high 1 edge after acceptance.
REQ-021 SHALL, on acceptance with length L>0, go to SHIFT; the remaining-length register starts at L.
REQ-022 SHALL perform one pass per cycle in SHIFT:
- step = min(remaining, 7);
- the shifter is driven with Enable_In=1, the latched mode, Shift_Bits_Length_In=step, Carry_In=carry register and Data_In=data register;
- Shifted_Data_Out and Carry_Out are registered back into the data and carry registers;
- remaining is reduced by step.
REQ-023 SHALL never issue a pass with step=0.
REQ-024 SHALL drive the shifter's Enable_In=0 outside SHIFT.
REQ-025 SHALL go from SHIFT to DONE on the edge where the remaining length becomes 0; passes P=ceil(L/7), and Rsp_Valid_Out is high P+1 edges after the acceptance edge.
REQ-026 SHALL hold Rsp_Data_Out and Rsp_Carry_Out equal to the data and carry registers, stable throughout DONE.
REQ-027 SHALL go from DONE to IDLE on an edge where Rsp_Ready_In=1; the next command can be accepted no earlier than the following edge.
REQ-028 SHALL hold the result indefinitely while Rsp_Ready_In=0 (backpressure), with no data or carry change.
REQ-029 SHALL produce results equal to a single L-bit operation:
- logical and arithmetic modes saturate at 8 or more bits (LSL/LSR give 0x00, ASR gives sign fill);
- ROL/ROR are modulo 8;
- RLC/RRC are modulo 9.
REQ-030 SHALL not reduce the length by any modulus internally; iteration alone provides these results.

Reset
REQ-031 SHALL, when Reset_In=0 at a rising edge, go to IDLE regardless of the current state, including mid-SHIFT and mid-DONE; the in-flight command is discarded.
REQ-032 SHALL reset every output and register as follows:
- Cmd_Ready_Out=1, Rsp_Valid_Out=0, Busy_Out=0;
- Rsp_Data_Out=0x00, Rsp_Carry_Out=0;
- remaining length=0.
REQ-033 SHALL give Reset_In priority over a simultaneous command or response handshake.

Verification
REQ-034 SHALL cover LSL, data 0x01, length 8, carry 0 -> passes of 7 then 1; result 0x00, carry 1; Rsp_Valid_Out high 3 edges after acceptance.
REQ-035 SHALL cover ROR, data 0xA5, length 20 -> passes of 7, 7 then 6; result 0x5A; Busy_Out high for 4 cycles before the response handshake.
REQ-036 SHALL cover RLC, data 0x00, carry 1, length 9 -> result 0x00, carry 1 (full 9-bit rotation); ASR, data 0x80, length 10 -> result 0xFF, carry 1.
REQ-037 SHALL cover length 0, data 0x3C, carry 1 -> result 0x3C, carry 1; Rsp_Valid_Out high 1 edge after acceptance.
REQ-038 SHALL cover holding Rsp_Ready_In=0 for 5 cycles in DONE -> outputs constant, Cmd_Ready_Out=0, and a Cmd_Valid_In pulse during that time is ignored.
REQ-039 SHALL cover Reset_In=0 for one edge during the second pass of the ROR 20 case -> next cycle IDLE, Rsp_Valid_Out=0, Rsp_Data_Out=0x00, Cmd_Ready_Out=1.
